// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: shared constants, register layout and address-region decode
// for the Game Boy cartridge-bus controllers.
package gb_cart_pkg;

  localparam logic [15:0] RAMEN_BASE = 16'h0000;
  localparam logic [15:0] BANK1_BASE = 16'h2000;
  localparam logic [15:0] BANK2_BASE = 16'h4000;
  localparam logic [15:0] MODE_BASE  = 16'h6000;
  localparam logic [15:0] VRAM_BASE  = 16'h8000;
  localparam logic [15:0] CRAM_BASE  = 16'hA000;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  localparam int BANK1_W    = 5;
  localparam int BANK2_W    = 2;
  localparam int ROM_OFS_W  = 14;
  localparam int RAM_OFS_W  = 13;
  localparam int ROM_FULL_W = BANK2_W + BANK1_W + ROM_OFS_W;
  localparam int RAM_FULL_W = BANK2_W + RAM_OFS_W;

  localparam logic [BANK1_W-1:0] BANK1_ONE  = 5'd1;
  localparam logic [BANK1_W-1:0] BANK1_ZERO = 5'd0;
  localparam logic [BANK2_W-1:0] BANK2_ZERO = 2'd0;

  typedef enum logic [2:0] {
    RGN_RAMEN = 3'd0,
    RGN_BANK1 = 3'd1,
    RGN_BANK2 = 3'd2,
    RGN_MODE  = 3'd3,
    RGN_VRAM  = 3'd4,
    RGN_CRAM  = 3'd5,
    RGN_HIGH  = 3'd6
  } region_e;

  typedef struct packed {
    logic               ram_en;
    logic [BANK1_W-1:0] bank1;
    logic [BANK2_W-1:0] bank2;
    logic               mode;
  } mbc_regs_t;

  localparam mbc_regs_t MBC_REGS_RST = '{
    ram_en: 1'b0,
    bank1:  5'd0,
    bank2:  2'd0,
    mode:   1'b0
  };

  // Every region is 8 KiB, so the top three address bits select it.
  function automatic region_e region_of(input logic [15:0] a);
    region_e r;
    case (a[15:13])
      RAMEN_BASE[15:13]: r = RGN_RAMEN;
      BANK1_BASE[15:13]: r = RGN_BANK1;
      BANK2_BASE[15:13]: r = RGN_BANK2;
      MODE_BASE[15:13]:  r = RGN_MODE;
      VRAM_BASE[15:13]:  r = RGN_VRAM;
      CRAM_BASE[15:13]:  r = RGN_CRAM;
      default:           r = RGN_HIGH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gb_bus_sync.sv
// gb_bus_sync: multi-stage synchronizer for an asynchronous bus vector,
// with a per-bit reset value so idle strobes come out of reset deasserted.
module gb_bus_sync #(
  parameter int               WIDTH   = 26,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift chain: stage 0 samples the raw bus, the last stage is the clean copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gb_mbc1_ctrl.sv
// gb_mbc1_ctrl: MBC1 bank controller for a cart bus sampled in the system clock domain.
// Build option: define MBC1_RAM_BANKING_EN to let bank2 select cart-RAM banks in mode 1.
module gb_mbc1_ctrl
  import gb_cart_pkg::*;
#(
  parameter int ROM_ADDR_BITS = 21,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_en,
  input  logic [15:0]              address,
  input  logic [7:0]               data_in,
  input  logic                     nWR,
  input  logic                     nRD,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic [14:0]              ram_addr,
  output logic                     ram_sel,
  output logic                     ram_wr,
  output logic [7:0]               ram_wdata
);

  localparam int SYNC_W = 16 + 8 + 1 + 1;
  localparam logic [SYNC_W-1:0] SYNC_RST = {16'h0000, 8'h00, 1'b1, 1'b1};

  logic [SYNC_W-1:0] sync_s;
  logic [15:0]       addr_s;
  logic [7:0]        data_s;
  logic              nwr_s;
  logic              nrd_s;

  logic              nwr_prev_q;
  logic [15:0]       addr_prev_q;
  logic [7:0]        data_prev_q;
  logic              commit_s;

  mbc_regs_t         regs_q, regs_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;

  logic [BANK1_W-1:0]       eff_bank1_s;
  logic [BANK2_W-1:0]       hi_bank_s;
  logic [BANK2_W-1:0]       ram_bank_s;
  logic [ROM_FULL_W-1:0]    rom_full_s;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic [RAM_FULL_W-1:0]    ram_addr_q, ram_addr_d;
  logic                     ram_sel_q, ram_sel_d;

  gb_bus_sync #(
    .WIDTH   (SYNC_W),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST)
  ) u_bus_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    ({address, data_in, nWR, nRD}),
    .q_o    (sync_s)
  );

  assign {addr_s, data_s, nwr_s, nrd_s} = sync_s;

  // Address and data are taken one clk before the nWR rising edge, while still stable.
  assign commit_s = bus_en & nwr_s & ~nwr_prev_q;

  // Register bank state, commit-edge history and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nwr_prev_q  <= 1'b1;
      addr_prev_q <= 16'h0000;
      data_prev_q <= 8'h00;
      regs_q      <= MBC_REGS_RST;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
      rom_addr_q  <= {ROM_ADDR_BITS{1'b0}};
      ram_addr_q  <= 15'h0000;
      ram_sel_q   <= 1'b0;
    end else begin
      nwr_prev_q  <= nwr_s;
      addr_prev_q <= addr_s;
      data_prev_q <= data_s;
      regs_q      <= regs_d;
      ram_wr_q    <= ram_wr_d;
      ram_wdata_q <= ram_wdata_d;
      rom_addr_q  <= rom_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
    end
  end

  // Commit decode: update control registers or launch a cart-RAM write.
  always_comb begin
    regs_d      = regs_q;
    ram_wr_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (commit_s) begin
      case (region_of(addr_prev_q))
        RGN_RAMEN: regs_d.ram_en = (data_prev_q[3:0] == RAM_EN_KEY);
        RGN_BANK1: regs_d.bank1  = data_prev_q[BANK1_W-1:0];
        RGN_BANK2: regs_d.bank2  = data_prev_q[BANK2_W-1:0];
        RGN_MODE:  regs_d.mode   = data_prev_q[0];
        RGN_CRAM: begin
          if (regs_q.ram_en) begin
            ram_wr_d    = 1'b1;
            ram_wdata_d = data_prev_q;
          end else begin
            ram_wr_d    = 1'b0;
          end
        end
        default:   regs_d = regs_q;
      endcase
    end else begin
      regs_d = regs_q;
    end
  end

  // Bank translation for the next registered ROM/RAM address and read select.
  always_comb begin
    eff_bank1_s = regs_q.bank1;
    if (regs_q.bank1 == BANK1_ZERO) begin
      eff_bank1_s = BANK1_ONE;
    end else begin
      eff_bank1_s = regs_q.bank1;
    end

    hi_bank_s = BANK2_ZERO;
    if (regs_q.mode) begin
      hi_bank_s = regs_q.bank2;
    end else begin
      hi_bank_s = BANK2_ZERO;
    end

`ifdef MBC1_RAM_BANKING_EN
    ram_bank_s = hi_bank_s;
`else
    ram_bank_s = BANK2_ZERO;
`endif

    rom_full_s = {ROM_FULL_W{1'b0}};
    if (addr_s[14]) begin
      rom_full_s = {regs_q.bank2, eff_bank1_s, addr_s[ROM_OFS_W-1:0]};
    end else begin
      rom_full_s = {hi_bank_s, BANK1_ZERO, addr_s[ROM_OFS_W-1:0]};
    end
    // Small ROMs simply drop the high bank bits and wrap.
    rom_addr_d = rom_full_s[ROM_ADDR_BITS-1:0];

    // During a RAM write pulse the address must match the committed write.
    ram_addr_d = {ram_bank_s, addr_s[RAM_OFS_W-1:0]};
    if (ram_wr_d) begin
      ram_addr_d = {ram_bank_s, addr_prev_q[RAM_OFS_W-1:0]};
    end else begin
      ram_addr_d = {ram_bank_s, addr_s[RAM_OFS_W-1:0]};
    end

    ram_sel_d = regs_q.ram_en & (region_of(addr_s) == RGN_CRAM) & ~nrd_s & nwr_s;
  end

  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wr    = ram_wr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_gb_mbc1_ctrl.sv
// tb_gb_mbc1_ctrl: table-driven bench for gb_mbc1_ctrl, with a second
// instance at ROM_ADDR_BITS=17 sharing the bus to observe address wrap.
module tb_gb_mbc1_ctrl;

  localparam int SYNC = 2;
`ifdef MBC1_RAM_BANKING_EN
  localparam bit BANKING = 1'b1;
`else
  localparam bit BANKING = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_en;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        nWR;
  logic        nRD;

  logic [20:0] rom_addr;
  logic [14:0] ram_addr;
  logic        ram_sel;
  logic        ram_wr;
  logic [7:0]  ram_wdata;

  logic [16:0] rom_addr17;
  logic [14:0] ram_addr17;
  logic        ram_sel17;
  logic        ram_wr17;
  logic [7:0]  ram_wdata17;

  always #10 clk = ~clk;

  gb_mbc1_ctrl #(.ROM_ADDR_BITS(21), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .address(address),
    .data_in(data_in), .nWR(nWR), .nRD(nRD), .rom_addr(rom_addr),
    .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wr(ram_wr), .ram_wdata(ram_wdata)
  );

  gb_mbc1_ctrl #(.ROM_ADDR_BITS(17), .SYNC_STAGES(SYNC)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .bus_en(bus_en), .address(address),
    .data_in(data_in), .nWR(nWR), .nRD(nRD), .rom_addr(rom_addr17),
    .ram_addr(ram_addr17), .ram_sel(ram_sel17), .ram_wr(ram_wr17), .ram_wdata(ram_wdata17)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          pulse_total = 0;
  logic [7:0]  last_wdata = 8'h00;
  logic [14:0] last_waddr = 15'h0000;

  // Count ram_wr high cycles; a single commit must give exactly one.
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      pulse_total = pulse_total + 1;
      last_wdata  = ram_wdata;
      last_waddr  = ram_addr;
    end
  end

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [20:0] rom;
    logic [16:0] rom17;
    logic [14:0] raddr;
    logic        sel;
    int          pulses;
    logic [7:0]  wdata;
    logic [14:0] waddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rd(input logic [15:0] a, input logic [20:0] rom,
                              input logic [16:0] rom17, input logic [14:0] raddr,
                              input logic sel);
    vec_t v;
    v.wr = 1'b0; v.a = a; v.d = 8'h00; v.rom = rom; v.rom17 = rom17;
    v.raddr = raddr; v.sel = sel; v.pulses = 0; v.wdata = 8'h00; v.waddr = 15'h0000;
    return v;
  endfunction

  function automatic vec_t wr(input logic [15:0] a, input logic [7:0] d,
                              input int pulses, input logic [7:0] wdata,
                              input logic [14:0] waddr);
    vec_t v;
    v.wr = 1'b1; v.a = a; v.d = d; v.rom = 21'h0; v.rom17 = 17'h0;
    v.raddr = 15'h0; v.sel = 1'b0; v.pulses = pulses; v.wdata = wdata; v.waddr = waddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output int pulses);
    int start;
    address = a;
    data_in = d;
    nRD     = 1'b1;
    nWR     = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = pulse_total;
    nWR   = 1'b1;
    repeat (SYNC + 5) @(posedge clk);
    #1;
    pulses = pulse_total - start;
  endtask

  task automatic bus_read(input logic [15:0] a);
    address = a;
    nWR     = 1'b1;
    nRD     = 1'b0;
    repeat (SYNC + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    int start;

    rst_n   = 1'b0;
    bus_en  = 1'b1;
    address = 16'h0000;
    data_in = 8'h00;
    nWR     = 1'b1;
    nRD     = 1'b1;

    vecs.push_back(rd(16'h4123, 21'h04123, 17'h04123, 15'h0123, 1'b0));
    vecs.push_back(wr(16'h2000, 8'h13, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h7FFF, 21'h4FFFF, 17'h0FFFF, 15'h1FFF, 1'b0));
    vecs.push_back(wr(16'h4000, 8'h01, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h7FFF, 21'hCFFFF, 17'h0FFFF, 15'h1FFF, 1'b0));
    vecs.push_back(rd(16'h0010, 21'h00010, 17'h00010, 15'h0010, 1'b0));
    vecs.push_back(wr(16'h6000, 8'h01, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'h4000, 8'h02, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h0010, 21'h100010, 17'h00010, BANKING ? 15'h4010 : 15'h0010, 1'b0));
    vecs.push_back(rd(16'h4000, 21'h14C000, 17'h0C000, BANKING ? 15'h4000 : 15'h0000, 1'b0));
    vecs.push_back(wr(16'h2000, 8'h00, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h5000, 21'h105000, 17'h05000, BANKING ? 15'h5000 : 15'h1000, 1'b0));
    vecs.push_back(wr(16'h2000, 8'h20, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h4000, 21'h104000, 17'h04000, BANKING ? 15'h4000 : 15'h0000, 1'b0));
    vecs.push_back(wr(16'h2000, 8'hFF, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h4000, 21'h17C000, 17'h1C000, BANKING ? 15'h4000 : 15'h0000, 1'b0));
    vecs.push_back(wr(16'h6000, 8'h00, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h0010, 21'h00010, 17'h00010, 15'h0010, 1'b0));
    vecs.push_back(wr(16'h0000, 8'h0A, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hA001, 8'h5C, 1, 8'h5C, 15'h0001));
    vecs.push_back(rd(16'hA123, 21'h02123, 17'h02123, 15'h0123, 1'b1));
    vecs.push_back(wr(16'h0000, 8'h00, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hA001, 8'h5C, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'hA123, 21'h02123, 17'h02123, 15'h0123, 1'b0));
    vecs.push_back(wr(16'h0000, 8'h1A, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hA002, 8'h33, 1, 8'h33, 15'h0002));
    vecs.push_back(wr(16'h0000, 8'hAB, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hA002, 8'h33, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'h8000, 8'h0A, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hA000, 8'h77, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hC000, 8'h01, 0, 8'h00, 15'h0000));
    vecs.push_back(wr(16'hE000, 8'h13, 0, 8'h00, 15'h0000));
    vecs.push_back(rd(16'h4000, 21'h17C000, 17'h1C000, 15'h0000, 1'b0));

    // Reset state, then the raw-to-output latency of SYNC+1 clocks.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_addr", rom_addr, 21'h0);
    check("rst_ram_addr", ram_addr, 15'h0);
    check("rst_ram_sel", ram_sel, 1'b0);
    check("rst_ram_wr", ram_wr, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    address = 16'h4123;
    repeat (SYNC) @(posedge clk);
    #1;
    check("lat_before", rom_addr, 21'h0);
    @(posedge clk);
    #1;
    check("lat_at", rom_addr, 21'h04123);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].a, vecs[i].d, p);
        check($sformatf("v%0d_pulses", i), p, vecs[i].pulses);
        if (vecs[i].pulses > 0) begin
          check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
          check($sformatf("v%0d_waddr", i), last_waddr, vecs[i].waddr);
        end
      end else begin
        bus_read(vecs[i].a);
        check($sformatf("v%0d_rom", i), rom_addr, vecs[i].rom);
        check($sformatf("v%0d_rom17", i), rom_addr17, vecs[i].rom17);
        check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].raddr);
        check($sformatf("v%0d_ram_sel", i), ram_sel, vecs[i].sel);
        nRD = 1'b1;
      end
    end

    // Writes with bus_en low must not touch bank1 (still 0x1F).
    bus_en = 1'b0;
    bus_write(16'h2000, 8'h05, p);
    bus_en = 1'b1;
    check("busen_pulses", p, 0);
    bus_read(16'h4000);
    check("busen_rom", rom_addr, 21'h17C000);
    nRD = 1'b1;

    // nRD and nWR low together is a write: no read select, then one commit.
    bus_write(16'h0000, 8'h0A, p);
    address = 16'hA123;
    data_in = 8'h99;
    nRD     = 1'b0;
    nWR     = 1'b0;
    repeat (SYNC + 3) @(posedge clk);
    #1;
    check("rdwr_sel", ram_sel, 1'b0);
    start = pulse_total;
    nWR = 1'b1;
    repeat (SYNC + 5) @(posedge clk);
    #1;
    check("rdwr_pulses", pulse_total - start, 1);
    check("rdwr_wdata", last_wdata, 8'h99);
    nRD = 1'b1;

    // Reset in the middle of a RAM write: outputs clear at once, write is lost.
    address = 16'hA005;
    data_in = 8'h42;
    nWR     = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = pulse_total;
    rst_n = 1'b0;
    #3;
    check("arst_rom_addr", rom_addr, 21'h0);
    check("arst_ram_wr", ram_wr, 1'b0);
    #5;
    rst_n = 1'b1;
    repeat (SYNC + 4) @(posedge clk);
    #1;
    check("arst_no_pulse", pulse_total - start, 0);
    nWR = 1'b1;
    repeat (SYNC + 5) @(posedge clk);
    #1;
    check("arst_ramen_clr", pulse_total - start, 0);
    bus_read(16'h4000);
    check("arst_rom", rom_addr, 21'h04000);
    check("arst_rom17", rom_addr17, 17'h04000);
    nRD = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
